// File: rtl/fpu_mult_round_norm_pkg.sv
// fpu_mult_round_norm_pkg: shared FPU rounding-mode encodings and per-format constants
package fpu_mult_round_norm_pkg;
    localparam logic [1:0] RM_RNE  = 2'b00;
    localparam logic [1:0] RM_RTZ  = 2'b01;
    localparam logic [1:0] RM_PINF = 2'b10;
    localparam logic [1:0] RM_NINF = 2'b11;
    localparam int SP_SW   = 24;
    localparam int SP_EW   = 8;
    localparam int SP_BIAS = 127;
    localparam int DP_SW   = 53;
    localparam int DP_EW   = 11;
    localparam int DP_BIAS = 1023;
    function automatic int fmt_bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction
endpackage

// File: rtl/fpu_mult_round_norm_round_inc.sv
// fpu_round_inc: combinational round-up decision from lsb, guard, sticky, sign and rounding mode
module fpu_round_inc
    import fpu_mult_round_norm_pkg::*;
(
    input  logic       i_lsb,
    input  logic       i_g,
    input  logic       i_s,
    input  logic       i_sign,
    input  logic [1:0] i_rmode,
    output logic       o_inc
);
    assign o_inc = (i_rmode == RM_RTZ)  ? 1'b0 :
                   (i_rmode == RM_PINF) ? (!i_sign & (i_g | i_s)) :
                   (i_rmode == RM_NINF) ? (i_sign & (i_g | i_s)) :
                                          (i_g & (i_s | i_lsb));
endmodule

// File: rtl/fpu_mult_round_norm.sv
// fpu_mult_round_norm: 2-stage normalize/round of a significand product with valid/ready backpressure.
// Define FPU_ROUND_MODES_EN to honour Rmode_i; otherwise round-to-nearest-even is fixed.
module fpu_mult_round_norm
    import fpu_mult_round_norm_pkg::*;
#(
    parameter int SW = SP_SW,
    parameter int EW = SP_EW
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2*SW-1:0] Data_P_i,
    input  logic            Sign_i,
    input  logic [EW+1:0]   Exp_i,
    input  logic [1:0]      Rmode_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic            Sign_o,
    output logic [SW-2:0]   Sgf_o,
    output logic [EW-1:0]   Exp_o,
    output logic            Overflow_o,
    output logic            Underflow_o
);
    logic            w_adv1, w_adv2, w_top, w_g, w_s, w_inc, w_ovf, w_unf, w_unused;
    logic [SW-1:0]   w_m;
    logic [EW+2:0]   w_e1, w_e2;
    logic [SW:0]     w_r;
    logic [SW-2:0]   w_frac;
    logic [1:0]      w_rm;
    logic            r_v1, r_g, r_s, r_sign1;
    logic [SW-1:0]   r_m;
    logic [EW+2:0]   r_e1;
    logic            r_v2, r_sign2, r_ovf, r_unf;
    logic [SW-2:0]   r_sgf;
    logic [EW-1:0]   r_exp;

    assign w_adv2  = !r_v2 | ready_i;
    assign w_adv1  = !r_v1 | w_adv2;
    assign ready_o = w_adv1;

    assign w_top = Data_P_i[2*SW-1];
    assign w_m   = w_top ? Data_P_i[2*SW-1:SW] : Data_P_i[2*SW-2:SW-1];
    assign w_g   = w_top ? Data_P_i[SW-1] : Data_P_i[SW-2];
    assign w_s   = w_top ? |Data_P_i[SW-2:0] : |Data_P_i[SW-3:0];
    // One extra bit of headroom keeps Exp_i+2 (normalize plus carry) from wrapping.
    assign w_e1  = {Exp_i[EW+1], Exp_i} + (EW+3)'(w_top);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_m     <= '0;
            r_g     <= 1'b0;
            r_s     <= 1'b0;
            r_e1    <= '0;
            r_sign1 <= 1'b0;
        end else begin
            if (w_adv1) r_v1 <= valid_i;
            if (valid_i & w_adv1) begin
                r_m     <= w_m;
                r_g     <= w_g;
                r_s     <= w_s;
                r_e1    <= w_e1;
                r_sign1 <= Sign_i;
            end
        end
    end

`ifdef FPU_ROUND_MODES_EN
    logic [1:0] r_rm1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rm1 <= RM_RNE;
        else if (valid_i & w_adv1) r_rm1 <= Rmode_i;
    end
    assign w_rm     = r_rm1;
    assign w_unused = w_r[SW-1];
`else
    assign w_rm     = RM_RNE;
    assign w_unused = w_r[SW-1] ^ (^Rmode_i);
`endif

    fpu_round_inc u_inc (
        .i_lsb  (r_m[0]),
        .i_g    (r_g),
        .i_s    (r_s),
        .i_sign (r_sign1),
        .i_rmode(w_rm),
        .o_inc  (w_inc)
    );

    assign w_r    = {1'b0, r_m} + (SW+1)'(w_inc);
    assign w_e2   = r_e1 + (EW+3)'(w_r[SW]);
    assign w_frac = w_r[SW] ? '0 : w_r[SW-2:0];
    assign w_ovf  = !w_e2[EW+2] & (w_e2[EW+1:0] >= {2'b00, {EW{1'b1}}});
    assign w_unf  = w_e2[EW+2] | (w_e2 == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2    <= 1'b0;
            r_sign2 <= 1'b0;
            r_sgf   <= '0;
            r_exp   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_adv2) r_v2 <= r_v1;
            if (r_v1 & w_adv2) begin
                r_sign2 <= r_sign1;
                r_sgf   <= (w_ovf | w_unf) ? '0 : w_frac;
                r_exp   <= w_ovf ? '1 : w_unf ? '0 : w_e2[EW-1:0];
                r_ovf   <= w_ovf;
                r_unf   <= w_unf;
            end
        end
    end

    assign valid_o     = r_v2;
    assign Sign_o      = r_sign2;
    assign Sgf_o       = r_sgf;
    assign Exp_o       = r_exp;
    assign Overflow_o  = r_ovf;
    assign Underflow_o = r_unf;
endmodule

// File: tb/tb_fpu_mult_round_norm.sv
// tb_fpu_mult_round_norm: scoreboard bench with directed and random products against an arithmetic reference model
module tb_fpu_mult_round_norm;
    import fpu_mult_round_norm_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, valid_i = 1'b0, ready_i = 1'b1, Sign_i = 1'b0;
    logic [47:0] Data_P_i = '0;
    logic [9:0]  Exp_i = '0;
    logic [1:0]  Rmode_i = '0;
    logic        ready_o, valid_o, Sign_o, Overflow_o, Underflow_o;
    logic [22:0] Sgf_o;
    logic [7:0]  Exp_o;

    always #5 clk = ~clk;

    fpu_mult_round_norm #(.SW(24), .EW(8)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .Data_P_i(Data_P_i),
        .Sign_i(Sign_i), .Exp_i(Exp_i), .Rmode_i(Rmode_i), .valid_o(valid_o), .ready_i(ready_i),
        .Sign_o(Sign_o), .Sgf_o(Sgf_o), .Exp_o(Exp_o), .Overflow_o(Overflow_o), .Underflow_o(Underflow_o)
    );

    typedef struct packed {
        logic        sign;
        logic [22:0] sgf;
        logic [7:0]  exp;
        logic        ovf;
        logic        unf;
    } res_t;

    typedef struct {
        logic [47:0] p;
        logic [9:0]  e;
        logic        sg;
        logic [1:0]  rm;
        res_t        x;
    } dir_t;

    res_t sb[$];
    int   n_cmp = 0, n_bad = 0;
    bit   rand_rdy = 1'b0;

    always @(posedge clk)
        if (!rst && valid_i && ready_o)
            assert (Data_P_i[47:46] != 2'b00) else $error("FAIL illegal_input: product %h has both top bits clear", Data_P_i);

    always @(negedge clk) if (rand_rdy) ready_i = ($urandom_range(0, 3) != 0);

    // Reference: value-level rounding of the product, no bit-slicing of guard/sticky.
    function automatic res_t model(input logic [47:0] p, input logic [9:0] e10, input logic sg, input logic [1:0] rm_in);
        res_t r;
        longint unsigned pv, m, rem, half;
        int sh, e;
        bit inc;
        logic [1:0] rm;
        rm = rm_in;
`ifndef FPU_ROUND_MODES_EN
        rm = RM_RNE;
`endif
        pv   = 64'(p);
        sh   = (pv >= (64'd1 << 47)) ? 24 : 23;
        m    = pv >> sh;
        rem  = pv - (m << sh);
        half = 64'd1 << (sh - 1);
        e    = int'($signed(e10)) + (sh - 23);
        if (rm == RM_RNE)       inc = (rem > half) || (rem == half && (m % 2) == 1);
        else if (rm == RM_RTZ)  inc = 1'b0;
        else if (rm == RM_PINF) inc = !sg && rem != 0;
        else                    inc = sg && rem != 0;
        m = m + 64'(inc);
        if (m == (64'd1 << 24)) begin
            m = 64'd1 << 23;
            e = e + 1;
        end
        r.sign = sg;
        r.ovf  = e >= 255;
        r.unf  = e <= 0;
        r.exp  = r.ovf ? 8'hFF : r.unf ? 8'h00 : 8'(e);
        r.sgf  = (r.ovf || r.unf) ? 23'h0 : 23'(m - (64'd1 << 23));
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic send(input logic [47:0] p, input logic [9:0] e, input logic sg, input logic [1:0] rm,
                        input res_t x, output int waits);
        waits = 0;
        @(negedge clk);
        valid_i = 1'b1; Data_P_i = p; Exp_i = e; Sign_i = sg; Rmode_i = rm;
        #4;
        while (!ready_o) begin
            if (waits > 500) begin
                n_cmp++; n_bad++;
                $display("FAIL send_timeout: ready_o stayed 0 for %0d cycles", waits);
                valid_i = 1'b0;
                return;
            end
            @(negedge clk); #4;
            waits++;
        end
        sb.push_back(x);
        @(posedge clk);
        #1 valid_i = 1'b0;
    endtask

    task automatic send_rand(output int w);
        logic [23:0] a, b;
        logic [47:0] p;
        logic [9:0]  e;
        logic        sg;
        logic [1:0]  rm;
        a  = {1'b1, 23'($urandom)};
        b  = {1'b1, 23'($urandom)};
        p  = {24'b0, a} * {24'b0, b};
        case ($urandom_range(0, 3))
            0:       e = 10'($urandom_range(250, 258));
            1:       e = 10'($urandom_range(0, 4)) - 10'd2;
            default: e = 10'($urandom_range(0, 300)) - 10'd20;
        endcase
        sg = 1'($urandom);
        rm = 2'($urandom);
        send(p, e, sg, rm, model(p, e, sg, rm), w);
    endtask

    task automatic drain();
        int c = 0;
        while (sb.size() > 0 && c < 1000) begin
            @(negedge clk);
            c++;
        end
        check("drain_queue_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin : monitor
        res_t hold, cur;
        bit   hp = 1'b0;
        forever begin
            @(negedge clk); #4;
            cur = {Sign_o, Sgf_o, Exp_o, Overflow_o, Underflow_o};
            if (rst) hp = 1'b0;
            else begin
                if (hp) check("stall_hold", {valid_o, cur}, {1'b1, hold});
                hp   = valid_o && !ready_i;
                hold = cur;
                if (valid_o && ready_i) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_output: got %h with empty scoreboard", cur);
                    end else check("result", 64'(cur), 64'(sb.pop_front()));
                end
            end
        end
    end

    initial begin : stim
        dir_t dl[$];
        int w, w1, w2;
        dl.push_back('{48'h400000000000, 10'd127, 1'b0, RM_RNE, '{1'b0, 23'h000000, 8'd127, 1'b0, 1'b0}});
        dl.push_back('{48'h900000000000, 10'd127, 1'b1, RM_RNE, '{1'b1, 23'h100000, 8'd128, 1'b0, 1'b0}});
        dl.push_back('{48'h7FFFFFC00000, 10'd100, 1'b0, RM_RNE, '{1'b0, 23'h000000, 8'd101, 1'b0, 1'b0}});
        dl.push_back('{48'h400000400000, 10'd127, 1'b0, RM_RNE, '{1'b0, 23'h000000, 8'd127, 1'b0, 1'b0}});
        dl.push_back('{48'h400000C00000, 10'd127, 1'b0, RM_RNE, '{1'b0, 23'h000002, 8'd127, 1'b0, 1'b0}});
        dl.push_back('{48'h900000000000, 10'd254, 1'b0, RM_RNE, '{1'b0, 23'h000000, 8'hFF, 1'b1, 1'b0}});
        dl.push_back('{48'h400000000000, 10'd0,   1'b1, RM_RNE, '{1'b1, 23'h000000, 8'h00, 1'b0, 1'b1}});
        dl.push_back('{48'h7FFFFFC00000, 10'd254, 1'b0, RM_RNE, '{1'b0, 23'h000000, 8'hFF, 1'b1, 1'b0}});
        dl.push_back('{48'h900000000000, 10'd253, 1'b0, RM_RNE, '{1'b0, 23'h100000, 8'd254, 1'b0, 1'b0}});
        dl.push_back('{48'h400000000000, 10'd1,   1'b0, RM_RNE, '{1'b0, 23'h000000, 8'd1, 1'b0, 1'b0}});
        dl.push_back('{48'h900000000000, 10'h3FF, 1'b0, RM_RNE, '{1'b0, 23'h000000, 8'h00, 1'b0, 1'b1}});
`ifdef FPU_ROUND_MODES_EN
        dl.push_back('{48'h400000C00000, 10'd127, 1'b0, RM_RTZ,  '{1'b0, 23'h000001, 8'd127, 1'b0, 1'b0}});
        dl.push_back('{48'h7FFFFFC00000, 10'd100, 1'b0, RM_RTZ,  '{1'b0, 23'h7FFFFF, 8'd100, 1'b0, 1'b0}});
        dl.push_back('{48'h400000000001, 10'd127, 1'b0, RM_PINF, '{1'b0, 23'h000001, 8'd127, 1'b0, 1'b0}});
        dl.push_back('{48'h400000000001, 10'd127, 1'b1, RM_PINF, '{1'b1, 23'h000000, 8'd127, 1'b0, 1'b0}});
        dl.push_back('{48'h400000000001, 10'd127, 1'b1, RM_NINF, '{1'b1, 23'h000001, 8'd127, 1'b0, 1'b0}});
`else
        dl.push_back('{48'h400000C00000, 10'd127, 1'b0, RM_RTZ,  '{1'b0, 23'h000002, 8'd127, 1'b0, 1'b0}});
        dl.push_back('{48'h400000000001, 10'd127, 1'b0, RM_PINF, '{1'b0, 23'h000000, 8'd127, 1'b0, 1'b0}});
`endif
        repeat (2) @(negedge clk);
        #4;
        check("reset_valid_o", 64'(valid_o), 64'd0);
        check("reset_ready_o", 64'(ready_o), 64'd1);
        check("reset_outputs", 64'({Sign_o, Sgf_o, Exp_o, Overflow_o, Underflow_o}), 64'd0);
        @(negedge clk) rst = 1'b0;
        foreach (dl[i]) send(dl[i].p, dl[i].e, dl[i].sg, dl[i].rm, dl[i].x, w);
        drain();
        rand_rdy = 1'b1;
        repeat (200) send_rand(w);
        rand_rdy = 1'b0;
        @(negedge clk) ready_i = 1'b1;
        drain();
        @(negedge clk) ready_i = 1'b0;
        send(dl[0].p, dl[0].e, dl[0].sg, dl[0].rm, dl[0].x, w1);
        send(dl[1].p, dl[1].e, dl[1].sg, dl[1].rm, dl[1].x, w2);
        check("bp_accept1_waits", 64'(w1), 64'd0);
        check("bp_accept2_waits", 64'(w2), 64'd0);
        @(negedge clk); #4;
        check("bp_ready_o_low", 64'(ready_o), 64'd0);
        fork
            send(dl[4].p, dl[4].e, dl[4].sg, dl[4].rm, dl[4].x, w);
            begin
                repeat (3) @(negedge clk);
                ready_i = 1'b1;
            end
        join
        send(dl[5].p, dl[5].e, dl[5].sg, dl[5].rm, dl[5].x, w);
        drain();
        @(negedge clk) ready_i = 1'b0;
        send(dl[2].p, dl[2].e, dl[2].sg, dl[2].rm, dl[2].x, w);
        send(dl[3].p, dl[3].e, dl[3].sg, dl[3].rm, dl[3].x, w);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("midreset_valid_o", 64'(valid_o), 64'd0);
        check("midreset_ready_o", 64'(ready_o), 64'd1);
        check("midreset_outputs", 64'({Sign_o, Sgf_o, Exp_o, Overflow_o, Underflow_o}), 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #4;
            check("post_reset_no_output", 64'(valid_o), 64'd0);
        end
        send(dl[8].p, dl[8].e, dl[8].sg, dl[8].rm, dl[8].x, w);
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
